// File: rtl/l4_ram_writer.sv
// l4_ram_writer: packs a stream of layer-3 results into 16-word bursts and
// writes them to the layer-4 activation RAM, in either overwrite or
// accumulate (read-modify-write) mode. One frame is four bursts.
// Optional feature: define L4_WR_SAT_EN for a signed saturating accumulate;
// without it the accumulate add wraps modulo 2^DW.
module l4_ram_writer #(
  parameter int unsigned DW     = 36,
  parameter int unsigned NBURST = 16,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(NBURST)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          first_pass,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [DW-1:0] dout_wr [NBURST-1:0],
  output logic          wr,
  output logic [AW-1:0] addr_wr,
  output logic [DW-1:0] din [NBURST-1:0],
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          mode_ovr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] buf_q [NBURST];
  logic          hs;
  logic          last_word;
  logic          last_burst;

  assign hs         = in_valid && in_ready;
  assign last_word  = (cnt == CW'(NBURST - 1));
  assign last_burst = (addr_wr == AW'(DEPTH - NBURST));

  // Accumulate add: wraps by default, signed saturating when enabled
  function automatic logic [DW-1:0] acc_add(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] s;
    s = a + b;
`ifdef L4_WR_SAT_EN
    if ((a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]))
      s = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: if (hs && last_word) state_d = S_WRITE;
      S_WRITE:   state_d = last_burst ? S_DONE : S_COLLECT;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state
  always_comb begin
    in_ready = 1'b0;
    wr       = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_IDLE:    busy     = 1'b0;
      S_COLLECT: in_ready = 1'b1;
      S_WRITE:   wr       = 1'b1;
      S_DONE:    done     = 1'b1;
      default:   busy     = 1'b0;
    endcase
  end

  // Datapath: mode latch, word counter, burst address and word buffer.
  // mode_ovr resets to overwrite so din reads the (cleared) buffer out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_ovr <= 1'b1;
      cnt      <= '0;
      addr_wr  <= '0;
      for (int i = 0; i < NBURST; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_ovr <= first_pass;
            cnt      <= '0;
            addr_wr  <= '0;
          end
        end
        S_COLLECT: begin
          if (hs) begin
            buf_q[cnt] <= in_data;
            cnt        <= cnt + CW'(1);
          end
        end
        S_WRITE: begin
          addr_wr <= addr_wr + AW'(NBURST);
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  // Burst write data: buffered words, optionally summed with current RAM contents
  always_comb begin
    for (int j = 0; j < NBURST; j++)
      din[j] = mode_ovr ? buf_q[j] : acc_add(buf_q[j], dout_wr[j]);
  end

endmodule

// File: tb/tb_l4_ram_writer.sv
// Directed bench for l4_ram_writer with a behavioural 64-word RAM model.
`timescale 1ns/1ps
module tb_l4_ram_writer;
  localparam int unsigned DW    = 36;
  localparam int unsigned NB    = 16;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          first_pass = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, wr, busy, done;
  logic [5:0]    addr_wr;
  logic [DW-1:0] dout_wr [NB-1:0];
  logic [DW-1:0] din [NB-1:0];

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] pre_img [DEPTH];
  logic [DW-1:0] stim    [DEPTH];
  logic          pre_en = 1'b0;

  int cyc = 0;
  int wcount = 0;
  int overlap_cnt = 0;
  logic [5:0]    wlog_addr [32];
  logic [DW-1:0] wlog_din  [32][NB];

  int n_chk = 0, n_pass = 0, n_fail = 0;

  l4_ram_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_pass(first_pass),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dout_wr(dout_wr), .wr(wr), .addr_wr(addr_wr), .din(din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: bulk preload from pre_img, or burst write on wr
  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pre_img[i];
    end else if (wr) begin
      for (int j = 0; j < NB; j++) ram[6'(addr_wr + 6'(j))] <= din[j];
    end
  end

  always_comb begin
    for (int j = 0; j < NB; j++) dout_wr[j] = ram[6'(addr_wr + 6'(j))];
  end

  // Write logger and wr/in_ready overlap detector
  always @(negedge clk) begin
    if (wr) begin
      if (wcount < 32) begin
        wlog_addr[wcount] = addr_wr;
        for (int j = 0; j < NB; j++) wlog_din[wcount][j] = din[j];
      end
      wcount = wcount + 1;
    end
    if (wr && in_ready) overlap_cnt = overlap_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram();
    pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic pulse_start(input logic fp, output int t);
    start = 1'b1;
    first_pass = fp;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int first, input int n, input bit gaps, input int restart_at);
    int  i = first;
    int  guard = 0;
    bit  hs;
    bit  rs = 1'b0;
    while (i < first + n && guard < 4000) begin
      in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = stim[i];
      if (i == restart_at && !rs) begin
        start = 1'b1;
        first_pass = 1'b0;
        rs = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("stream_bound", DW'(guard < 4000), DW'(1));
  endtask

  // Waits for done, then returns one cycle later (IDLE)
  task automatic wait_done(output int t_done);
    int k = 0;
    t_done = -1;
    while (k < 300) begin
      @(negedge clk);
      if (done) begin
        t_done = cyc;
        break;
      end
      k++;
    end
    check("done_seen", DW'(done), DW'(1));
    check("addr_in_done", DW'(addr_wr), DW'(0));
    tick();
    check("done_one_cycle", DW'(done), DW'(0));
    check("idle_after_done", DW'(busy), DW'(0));
  endtask

  initial begin
    int t0, td, b, bad;

    // Reset state, with nonzero RAM contents behind dout_wr
    for (int i = 0; i < DEPTH; i++) pre_img[i] = DW'(7);
    load_ram();
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_wr", DW'(wr), DW'(0));
    check("rst_addr", DW'(addr_wr), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    rst_n = 1'b1;
    tick();
    check("rst_din0", din[0], DW'(0));
    check("rst_din15", din[15], DW'(0));
    check("idle_ready", DW'(in_ready), DW'(0));

    // Overwrite frame, in_valid held high
    for (int i = 0; i < DEPTH; i++) stim[i] = DW'(i);
    b = wcount;
    pulse_start(1'b1, t0);
    check("start_busy", DW'(busy), DW'(1));
    check("start_ready", DW'(in_ready), DW'(1));
    send_words(0, 64, 1'b0, -1);
    wait_done(td);
    check("ovr_latency", DW'(td - t0), DW'(69));
    check("ovr_wr_count", DW'(wcount - b), DW'(4));
    for (int k = 0; k < 4; k++) check("ovr_addr", DW'(wlog_addr[b + k]), DW'(16 * k));
    for (int j = 0; j < NB; j++) check("ovr_burst16_din", wlog_din[b + 1][j], DW'(16 + j));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== DW'(i)) bad++;
    check("ovr_ram_bad", DW'(bad), DW'(0));

    // Accumulate frame, started back-to-back in the cycle after done
    for (int i = 0; i < DEPTH; i++) pre_img[i] = DW'(5);
    for (int i = 0; i < DEPTH; i++) stim[i] = DW'(3);
    pre_en = 1'b1;
    b = wcount;
    pulse_start(1'b0, t0);
    pre_en = 1'b0;
    check("b2b_start_busy", DW'(busy), DW'(1));
    send_words(0, 64, 1'b0, -1);
    wait_done(td);
    check("acc_wr_count", DW'(wcount - b), DW'(4));
    check("acc_din0", wlog_din[b][0], DW'(8));
    bad = 0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < NB; j++) if (wlog_din[b + k][j] !== DW'(8)) bad++;
    check("acc_din_bad", DW'(bad), DW'(0));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== DW'(8)) bad++;
    check("acc_ram_bad", DW'(bad), DW'(0));

    // Overflow in accumulate mode
    for (int i = 0; i < DEPTH; i++) pre_img[i] = '0;
    pre_img[0] = 36'h7_FFFF_FFFF;
    pre_img[1] = 36'h8_0000_0000;
    pre_img[2] = DW'(10);
    for (int i = 0; i < DEPTH; i++) stim[i] = '0;
    stim[0] = DW'(1);
    stim[1] = 36'hF_FFFF_FFFF;
    stim[2] = 36'hF_FFFF_FFFD;
    load_ram();
    b = wcount;
    pulse_start(1'b0, t0);
    send_words(0, 64, 1'b0, -1);
    wait_done(td);
`ifdef L4_WR_SAT_EN
    check("ovf_pos_din0", wlog_din[b][0], 36'h7_FFFF_FFFF);
    check("ovf_neg_din1", wlog_din[b][1], 36'h8_0000_0000);
    check("ovf_pos_ram0", ram[0], 36'h7_FFFF_FFFF);
`else
    check("ovf_pos_din0", wlog_din[b][0], 36'h8_0000_0000);
    check("ovf_neg_din1", wlog_din[b][1], 36'h7_FFFF_FFFF);
    check("ovf_pos_ram0", ram[0], 36'h8_0000_0000);
`endif
    check("ovf_plain_din2", wlog_din[b][2], DW'(7));

    // Backpressure with random gaps and a start pulse mid-frame
    for (int i = 0; i < DEPTH; i++) pre_img[i] = DW'(100);
    for (int i = 0; i < DEPTH; i++) stim[i] = DW'(i);
    load_ram();
    b = wcount;
    pulse_start(1'b1, t0);
    send_words(0, 64, 1'b1, 20);
    wait_done(td);
    check("bp_wr_count", DW'(wcount - b), DW'(4));
    for (int k = 0; k < 4; k++) check("bp_addr", DW'(wlog_addr[b + k]), DW'(16 * k));
    for (int j = 0; j < NB; j++) check("bp_burst16_din", wlog_din[b + 1][j], DW'(16 + j));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== DW'(i)) bad++;
    check("bp_ram_bad", DW'(bad), DW'(0));
    check("wr_with_ready", DW'(overlap_cnt), DW'(0));

    // Reset mid-frame after 20 handshakes
    for (int i = 0; i < DEPTH; i++) stim[i] = DW'(1000 + i);
    pulse_start(1'b1, t0);
    send_words(0, 20, 1'b0, -1);
    check("pre_rst_addr", DW'(addr_wr), DW'(16));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", DW'(in_ready), DW'(0));
    check("arst_busy", DW'(busy), DW'(0));
    check("arst_wr", DW'(wr), DW'(0));
    check("arst_done", DW'(done), DW'(0));
    check("arst_addr", DW'(addr_wr), DW'(0));
    check("arst_din0", din[0], DW'(0));
    b = wcount;
    tick();
    tick();
    check("no_wr_in_reset", DW'(wcount - b), DW'(0));
    rst_n = 1'b1;
    tick();
    b = wcount;
    pulse_start(1'b1, t0);
    send_words(0, 64, 1'b0, -1);
    wait_done(td);
    check("post_rst_wr_count", DW'(wcount - b), DW'(4));
    check("post_rst_addr0", DW'(wlog_addr[b]), DW'(0));
    check("post_rst_din0", wlog_din[b][0], DW'(1000));
    check("post_rst_ram63", ram[63], DW'(1063));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
